// File: rtl/pool_pkg.sv
// ============================================================================
// pool_pkg : shared types and the combine operator for the 2x2 pooling stage
// Rev 1.0
// ============================================================================
`default_nettype none

package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  localparam int ACC_EXTRA = 2;

  // combine works on one fixed wide type; callers sign-extend in and truncate out
  localparam int POOL_MAX_DATA_W = 64;
  localparam int POOL_WIDE_W     = POOL_MAX_DATA_W + ACC_EXTRA;

  typedef logic signed [POOL_WIDE_W-1:0] pool_wide_t;

  function automatic pool_wide_t pool_combine(
    input pool_mode_e mode,
    input pool_wide_t a,
    input pool_wide_t b
  );
    if (mode == POOL_AVG) begin
      return a + b;
    end
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool_rowbuf.sv
// ============================================================================
// pool_rowbuf : per-column partial-result store, one write port, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module pool_rowbuf #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 34,
  parameter int AW    = 2
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic signed [WIDTH-1:0] rd_data
);

  logic signed [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/pool2x2_stream.sv
// ============================================================================
// pool2x2_stream : streaming 2x2 / stride-2 max or average pooling stage
// Rev 1.0
// ============================================================================
`default_nettype none

module pool2x2_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FM_W   = 6,
  parameter int FM_H   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int ACC_W  = DATA_W + ACC_EXTRA;
  localparam int CW     = $clog2(FM_W);
  localparam int RW     = $clog2(FM_H);
  localparam int BUF_D  = FM_W / 2;
  localparam int BUF_AW = (BUF_D > 1) ? $clog2(BUF_D) : 1;

  localparam logic [CW-1:0] c_COL_LAST = CW'(FM_W - 1);
  localparam logic [RW-1:0] c_ROW_LAST = RW'(FM_H - 1);

  if ((FM_W < 2) || ((FM_W % 2) != 0)) begin : g_bad_fm_w
    $error("pool2x2_stream: FM_W must be even and >= 2");
  end
  if ((FM_H < 2) || ((FM_H % 2) != 0)) begin : g_bad_fm_h
    $error("pool2x2_stream: FM_H must be even and >= 2");
  end
  if ((DATA_W < 1) || (DATA_W > POOL_MAX_DATA_W)) begin : g_bad_data_w
    $error("pool2x2_stream: DATA_W out of supported range");
  end

  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  pool_mode_e              r_mode;
  logic signed [ACC_W-1:0] r_pair;
  logic                    r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic                    r_out_last;
  logic                    r_busy;

  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_first;
  logic                    w_col_odd;
  logic                    w_row_odd;
  logic                    w_frame_end;
  logic                    w_result_en;
  logic                    w_rb_wr_en;
  pool_mode_e              w_mode;
  logic [BUF_AW-1:0]       w_rb_addr;
  logic signed [ACC_W-1:0] w_pix;
  logic signed [ACC_W-1:0] w_pair_comb;
  logic signed [ACC_W-1:0] w_rb_rdata;
  logic signed [ACC_W-1:0] w_res;
  logic signed [ACC_W-1:0] w_final;

  // single-entry output register: accept input only if the slot is free or draining
  assign in_ready    = !r_out_valid || out_ready;
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_out_valid && out_ready;

  assign w_first     = (r_row == '0) && (r_col == '0);
  assign w_col_odd   = r_col[0];
  assign w_row_odd   = r_row[0];
  assign w_frame_end = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
  assign w_result_en = w_in_fire && w_row_odd && w_col_odd;
  assign w_rb_wr_en  = w_in_fire && !w_row_odd && w_col_odd;

  // pixel (0,0) itself must see the new frame mode before the register loads
  assign w_mode      = w_first ? pool_mode_e'(mode) : r_mode;

  assign w_pix       = ACC_W'(in_data);
  assign w_rb_addr   = BUF_AW'(r_col >> 1);

  assign w_pair_comb = ACC_W'(pool_combine(w_mode, pool_wide_t'(r_pair), pool_wide_t'(w_pix)));
  assign w_res       = ACC_W'(pool_combine(w_mode, pool_wide_t'(w_rb_rdata), pool_wide_t'(w_pair_comb)));
  assign w_final     = (w_mode == POOL_AVG) ? (w_res >>> 2) : w_res;

  pool_rowbuf #(
    .DEPTH (BUF_D),
    .WIDTH (ACC_W),
    .AW    (BUF_AW)
  ) u_rowbuf (
    .clk     (clk),
    .wr_en   (w_rb_wr_en),
    .wr_addr (w_rb_addr),
    .wr_data (w_pair_comb),
    .rd_addr (w_rb_addr),
    .rd_data (w_rb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_mode <= POOL_MAX;
      r_pair <= '0;
    end else if (w_in_fire) begin
      if (w_first) begin
        r_mode <= pool_mode_e'(mode);
      end
      if (!w_col_odd) begin
        r_pair <= w_pix;
      end
      if (r_col == c_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_result_en) begin
      r_out_valid <= 1'b1;
      r_out_data  <= DATA_W'(w_final);
      r_out_last  <= w_frame_end;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // a new frame starting on the frame_done cycle keeps busy high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else if (w_in_fire && w_first) begin
      r_busy <= 1'b1;
    end else if (frame_done) begin
      r_busy <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign frame_done = w_out_fire && r_out_last;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pool2x2_stream.sv
// ============================================================================
// tb_pool2x2_stream : directed self-checking bench for pool2x2_stream
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pool2x2_stream;

  localparam int DW    = 32;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [DW-1:0] out_data;
  logic out_last;
  logic frame_done;
  logic busy;

  pool2x2_stream #(
    .DATA_W (DW),
    .FM_W   (6),
    .FM_H   (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic signed [DW-1:0] stim[$];
  bit                   mode_q[$];
  logic signed [DW-1:0] got_q[$];
  bit                   last_q[$];
  int                   exp_q[$];
  int                   done_cnt;

  int RAMP_MAX[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
  int RAMP_AVG[9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};

  task automatic check(input string tag, input logic signed [63:0] got_v,
                       input logic signed [63:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  // ramp frame 0..35; mode switches to !m from pixel flip_at onward
  task automatic add_frame(input bit m, input int flip_at);
    for (int i = 0; i < 36; i++) begin
      stim.push_back(DW'(i));
      mode_q.push_back((i >= flip_at) ? !m : m);
    end
  endtask

  task automatic load_exp(input bit avg);
    for (int i = 0; i < 9; i++) exp_q.push_back(avg ? RAMP_AVG[i] : RAMP_MAX[i]);
  endtask

  task automatic clear_all();
    stim.delete();
    mode_q.delete();
    exp_q.delete();
  endtask

  task automatic run_stream(input bit rand_ready);
    int idx = 0;
    int cyc = 0;
    bit busy_seen = 0;
    bit prev_held = 0;
    logic signed [DW-1:0] prev_data = '0;
    bit prev_last = 0;
    got_q.delete();
    last_q.delete();
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (idx >= stim.size() && !out_valid) break;
      if (cyc >= LIMIT) break;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (idx < stim.size());
      in_data   = in_valid ? stim[idx] : '0;
      mode      = in_valid ? mode_q[idx] : 1'b0;
      #1;
      if (prev_held) begin
        check("held_valid", out_valid, 1);
        check("held_data", out_data, prev_data);
        check("held_last", out_last, prev_last);
      end
      if (out_valid && !out_ready) check("in_ready_held", in_ready, 0);
      if (frame_done || (out_valid && out_ready && out_last))
        check("frame_done_align", frame_done, out_valid && out_ready && out_last);
      if (!busy_seen && idx == 3) begin
        check("busy_midframe", busy, 1);
        busy_seen = 1;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (frame_done) done_cnt++;
      prev_held = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_timeout", cyc < LIMIT, 1);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_q[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), last_q[i], (i % 9) == 8);
    end
    check({tag, "_done"}, done_cnt, exp_q.size() / 9);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    clear_all(); add_frame(0, 36); load_exp(0);
    run_stream(0); check_outputs("ramp_max");

    clear_all(); add_frame(1, 36); load_exp(1);
    run_stream(0); check_outputs("ramp_avg");

    // negative window in the top-left pooled cell
    clear_all(); add_frame(1, 36);
    stim[0] = -1; stim[1] = -2; stim[6] = -3; stim[7] = -4;
    load_exp(1); exp_q[0] = -3;
    run_stream(0); check_outputs("neg_tl_avg");

    clear_all(); add_frame(0, 36);
    stim[0] = -1; stim[1] = -2; stim[6] = -3; stim[7] = -4;
    load_exp(0); exp_q[0] = -1;
    run_stream(0); check_outputs("neg_tl_max");

    // negative window in the final pooled cell
    clear_all(); add_frame(0, 36);
    stim[28] = -5; stim[29] = -3; stim[34] = -8; stim[35] = -7;
    load_exp(0); exp_q[8] = -3;
    run_stream(0); check_outputs("neg_br_max");

    clear_all(); add_frame(1, 36);
    stim[28] = -5; stim[29] = -3; stim[34] = -8; stim[35] = -7;
    load_exp(1); exp_q[8] = -6;
    run_stream(0); check_outputs("neg_br_avg");

    clear_all(); add_frame(0, 36); load_exp(0);
    run_stream(1); check_outputs("bp_max");

    // mode flips to avg at pixel 10; the following frame starts in avg
    clear_all(); add_frame(0, 10); add_frame(1, 36);
    load_exp(0); load_exp(1);
    run_stream(0); check_outputs("mode_flip");

    // abandon a frame after 20 pixels
    clear_all();
    for (int i = 0; i < 20; i++) begin
      stim.push_back(DW'(i));
      mode_q.push_back(1'b0);
    end
    run_stream(0);
    check("partial_busy", busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_out_valid", out_valid, 0);
    clear_all(); add_frame(0, 36); load_exp(0);
    run_stream(0); check_outputs("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
